// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the serial blocks.
// PISO_PARITY_EN appends an even-parity bit to every frame.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

`ifdef PISO_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 32
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             shift_en;
    logic             out;
    logic             out_valid;
    logic             out_last;

    modport master (
        output load_valid, load_data, shift_en,
        input  load_ready, out, out_valid, out_last
    );

    modport slave (
        input  load_valid, load_data, shift_en,
        output load_ready, out, out_valid, out_last
    );
endinterface

// File: rtl/piso_bit_counter.sv
// Bit position counter: clear on load, count on enable, flag at LAST.
module piso_bit_counter #(
    parameter int CW   = 6,
    parameter int LAST = 31
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == CW'(LAST));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with load handshake and frame counter.
// Define PISO_PARITY_EN to append an even-parity bit to each frame.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MSB_FIRST = 0,
    parameter int FCNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    piso_serializer_if.slave  bus,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int FLEN = WIDTH + PAR_BITS;
    localparam int LAST = FLEN - 1;
    localparam int CW   = clog2(WIDTH + 1);

    state_t            state;
    logic [FLEN-1:0]   shreg;
    logic [FLEN-1:0]   init;
    logic [FLEN-1:0]   shifted;
    logic [CW-1:0]     cnt;
    logic              tc;
    logic              busy;
    logic              done;
    logic              fire;
    logic              adv;

`ifdef PISO_PARITY_EN
    logic par;
    assign par  = ^bus.load_data;
    // parity always trails the data bits, whichever end shifts out
    assign init = (MSB_FIRST != 0) ? {bus.load_data, par}
                                   : {par, bus.load_data};
`else
    assign init = bus.load_data;
`endif

    assign shifted = (MSB_FIRST != 0) ? {shreg[FLEN-2:0], 1'b0}
                                      : {1'b0, shreg[FLEN-1:1]};

    assign busy = (state == ST_SHIFT);
    assign done = busy & tc & bus.shift_en;
    assign adv  = busy & bus.shift_en & ~tc;
    assign fire = bus.load_valid & bus.load_ready;

    assign bus.load_ready = ~busy | done;
    assign bus.out_valid  = busy;
    assign bus.out_last   = busy & tc;
    assign bus.out        = busy & ((MSB_FIRST != 0) ? shreg[FLEN-1]
                                                     : shreg[0]);

    piso_bit_counter #(
        .CW   (CW),
        .LAST (LAST)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (fire),
        .en    (adv),
        .cnt   (cnt),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            frame_cnt <= '0;
        end else begin
            if (done) frame_cnt <= frame_cnt + FCNT_W'(1);
            if (fire) begin
                shreg <= init;
                state <= ST_SHIFT;
            end else if (done) begin
                state <= ST_IDLE;
            end else if (adv) begin
                shreg <= shifted;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: LSB-first 32-bit lane and MSB-first 8-bit lane.
module tb_piso_serializer;

    localparam int W0  = 32;
    localparam int W1  = 8;
    localparam int FW0 = 8;
    localparam int FW1 = 2;
`ifdef PISO_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(W0)) if0 ();
    piso_serializer_if #(.WIDTH(W1)) if1 ();
    logic [FW0-1:0] fc0;
    logic [FW1-1:0] fc1;

    piso_serializer #(.WIDTH(W0), .MSB_FIRST(0), .FCNT_W(FW0)) dut0 (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (if0.slave),
        .frame_cnt (fc0)
    );

    piso_serializer #(.WIDTH(W1), .MSB_FIRST(1), .FCNT_W(FW1)) dut1 (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (if1.slave),
        .frame_cnt (fc1)
    );

    typedef struct packed {
        logic b;
        logic l;
    } sbit_t;

    sbit_t q[2][$];
    int    fcm[2];
    int    cons[2];
    int    run[2];
    int    maxrun[2];
    bit    acc[2];
    bit    rnd = 1'b0;
    int    nchk = 0;
    int    nerr = 0;

    task automatic chk(string nm, int lane, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s lane%0d: got %0h expected %0h at %0t",
                     nm, lane, act, exp, $time);
        end
    endtask

    // Expected bit stream of one frame, straight from the ordering rules.
    function automatic void push_frame(int lane, logic [31:0] d, int w, bit msb);
        logic p;
        int   n;
        p = 1'b0;
        n = w + PB;
        for (int i = 0; i < w; i++) p = p ^ d[i];
        for (int i = 0; i < n; i++) begin
            sbit_t s;
            if (i < w) s.b = msb ? d[w-1-i] : d[i];
            else       s.b = p;
            s.l = (i == n - 1);
            q[lane].push_back(s);
        end
    endfunction

    task automatic mon(int lane, logic v, logic o, logic l, logic r,
                       logic se, logic lv, logic [31:0] d,
                       logic [31:0] fc, int w, bit msb, int fw);
        bit e, eo, el, er;
        e  = (q[lane].size() == 0);
        eo = e ? 1'b0 : q[lane][0].b;
        el = e ? 1'b0 : q[lane][0].l;
        er = e || (el && se);
        chk("out_valid", lane, 32'(v), 32'(!e));
        chk("out", lane, 32'(o), 32'(eo));
        chk("out_last", lane, 32'(l), 32'(el));
        chk("load_ready", lane, 32'(r), 32'(er));
        chk("frame_cnt", lane, fc, 32'(fcm[lane] % (1 << fw)));
        if (v === 1'b1) run[lane]++;
        else run[lane] = 0;
        if (run[lane] > maxrun[lane]) maxrun[lane] = run[lane];
        if (!rst_n) begin
            q[lane].delete();
            fcm[lane] = 0;
        end else begin
            if (!e && se) begin
                if (el) fcm[lane]++;
                void'(q[lane].pop_front());
                cons[lane]++;
            end
            if (lv && er) push_frame(lane, d, w, msb);
        end
    endtask

    always @(negedge clk) begin
        mon(0, if0.out_valid, if0.out, if0.out_last, if0.load_ready,
            if0.shift_en, if0.load_valid, if0.load_data, 32'(fc0),
            W0, 1'b0, FW0);
        mon(1, if1.out_valid, if1.out, if1.out_last, if1.load_ready,
            if1.shift_en, if1.load_valid, 32'(if1.load_data), 32'(fc1),
            W1, 1'b1, FW1);
    end

    task automatic tick();
        @(negedge clk);
        acc[0] = if0.load_valid && if0.load_ready && rst_n;
        acc[1] = if1.load_valid && if1.load_ready && rst_n;
        @(posedge clk);
        #1;
        if (rnd) begin
            if (acc[0] || !if0.load_valid) begin
                if0.load_valid = ($urandom % 3 == 0);
                if0.load_data  = $urandom;
            end
            if (acc[1] || !if1.load_valid) begin
                if1.load_valid = ($urandom % 3 == 0);
                if1.load_data  = 8'($urandom);
            end
            if0.shift_en = ($urandom % 4 != 0);
            if1.shift_en = ($urandom % 4 != 0);
        end
    endtask

    task automatic send(int lane, logic [31:0] d);
        int t;
        t = 0;
        if (lane == 0) begin
            if0.load_valid = 1'b1;
            if0.load_data  = d;
        end else begin
            if1.load_valid = 1'b1;
            if1.load_data  = d[7:0];
        end
        do begin
            tick();
            t++;
        end while (!acc[lane] && t < 200);
        chk("load_accept", lane, 32'(acc[lane]), 32'd1);
        if (lane == 0) if0.load_valid = 1'b0;
        else           if1.load_valid = 1'b0;
    endtask

    task automatic wait_idle(int lane);
        int t;
        t = 0;
        while (q[lane].size() != 0 && t < 2000) begin
            tick();
            t++;
        end
        chk("drain", lane, 32'(q[lane].size()), 32'd0);
    endtask

    task automatic wait_cons(int lane, int n);
        int t;
        t = 0;
        while (cons[lane] < n && t < 500) begin
            tick();
            t++;
        end
        chk("bit_progress", lane, 32'(cons[lane] >= n), 32'd1);
    endtask

    initial begin
        int base;
        if0.load_valid = 1'b1;
        if0.load_data  = 32'd456;
        if0.shift_en   = 1'b1;
        if1.load_valid = 1'b1;
        if1.load_data  = 8'h5a;
        if1.shift_en   = 1'b0;

        // two reset cycles with a load pending: nothing may load
        tick();
        tick();
        chk("rst_valid", 0, 32'(if0.out_valid), 32'd0);
        chk("rst_ready", 0, 32'(if0.load_ready), 32'd1);
        chk("rst_fcnt", 0, 32'(fc0), 32'd0);
        chk("rst_valid", 1, 32'(if1.out_valid), 32'd0);
        if1.load_valid = 1'b0;
        rst_n = 1'b1;

        send(0, 32'd456);
        wait_idle(0);
        chk("fcnt_after_456", 0, 32'(fc0), 32'd1);
        chk("idle_ready", 0, 32'(if0.load_ready), 32'd1);

        maxrun[0] = 0;
        send(0, 32'd456);
        send(0, 32'd123);
        wait_idle(0);
        chk("gapless_run", 0, 32'(maxrun[0]), 32'(2 * (W0 + PB)));
        chk("fcnt_b2b", 0, 32'(fc0), 32'd3);

        base = cons[0];
        send(0, $urandom);
        wait_cons(0, base + 10);
        if0.shift_en = 1'b0;
        repeat (5) tick();
        if0.shift_en = 1'b1;
        wait_cons(0, base + 20);
        if0.load_valid = 1'b1;
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", 0, 32'(if0.out_valid), 32'd0);
        chk("midrst_fcnt", 0, 32'(fc0), 32'd0);
        if0.load_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        if1.shift_en = 1'b1;
        send(1, 32'h07);
        wait_idle(1);
        send(1, 32'h03);
        wait_idle(1);
        chk("fcnt_two", 1, 32'(fc1), 32'd2);
        send(1, 32'h5a);
        send(1, 32'hc3);
        wait_idle(1);
        chk("fcnt_wrap", 1, 32'(fc1), 32'd0);

        rnd = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (i == 1500) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end
        rnd = 1'b0;
        if0.load_valid = 1'b0;
        if1.load_valid = 1'b0;
        if0.shift_en   = 1'b1;
        if1.shift_en   = 1'b1;
        wait_idle(0);
        wait_idle(1);
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
